// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bus: pipeline writeback, long-latency results and
// the arbitrated register-file write. The arbiter takes the slave side.
interface wb_port_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Handshake: a long-latency result transfers on a cycle where ll_valid and
    // ll_ready are both high; ll_ready never depends on the same-cycle pipeline write.
    modport slave (
        input  wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        output ll_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        input  ll_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between in-order writeback and buffered
// long-latency results; an age counter forces a drain so buffered results cannot starve.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_age;

    logic w_empty;
    logic w_full;
    logic w_wb_write;
    logic w_force;
    logic w_pop;
    logic w_push;
    logic w_ready;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_wb_write = bus.wb_valid && (bus.wb_rd != 5'd0);
    assign w_force    = !w_empty && (r_age == AW'(MAX_WAIT));
    assign w_pop      = rst_n && !w_empty && (w_force || !w_wb_write);
    assign w_ready    = rst_n && !w_full;
    // Writes to r0 complete the handshake but are dropped rather than stored.
    assign w_push     = bus.ll_valid && w_ready && (bus.ll_rd != 5'd0);

    assign bus.ll_ready = w_ready;

    always_comb begin
        bus.rf_we      = 1'b0;
        bus.rf_waddr   = 5'd0;
        bus.rf_wdata   = 32'd0;
        bus.pipe_stall = 1'b0;
        if (rst_n) begin
            if (w_force) begin
                bus.rf_we      = 1'b1;
                bus.rf_waddr   = r_mem_rd[r_rptr];
                bus.rf_wdata   = r_mem_data[r_rptr];
                bus.pipe_stall = 1'b1;
            end else if (w_wb_write) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_rd;
                bus.rf_wdata = bus.wb_data;
            end else if (!w_empty) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = r_mem_rd[r_rptr];
                bus.rf_wdata = r_mem_data[r_rptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.ll_rd;
            r_mem_data[r_wptr] <= bus.ll_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_age   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // Age measures how long the current head has waited for a slot.
            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age != AW'(MAX_WAIT)) begin
                r_age <= r_age + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst_n;
  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: buffered LL results in arrival order, head age
  logic [36:0] exp_q[$];
  int          exp_age;
  int          n_checks;
  int          n_fail;

  // last observed values, for directed scenario bookkeeping
  logic obs_ready;
  logic obs_stall;
  logic obs_we;
  logic [4:0] obs_waddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'd0;
    bus.ll_valid = 1'b0;
    bus.ll_rd    = 5'd0;
    bus.ll_data  = 32'd0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic        e_ready, e_stall, e_we, e_pop, e_push;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          sz;
    @(negedge clk);
    bus.wb_valid = wv;
    bus.wb_rd    = wrd;
    bus.wb_data  = wd;
    bus.ll_valid = lv;
    bus.ll_rd    = lrd;
    bus.ll_data  = ld;
    #1;
    sz      = exp_q.size();
    e_ready = (sz < DEPTH);
    e_stall = 1'b0;
    e_we    = 1'b0;
    e_addr  = 5'd0;
    e_data  = 32'd0;
    e_pop   = 1'b0;
    if (sz > 0 && exp_age >= MAX_WAIT) begin
      e_stall = 1'b1;
      e_pop   = 1'b1;
    end else if (wv && wrd != 5'd0) begin
      e_we   = 1'b1;
      e_addr = wrd;
      e_data = wd;
    end else if (sz > 0) begin
      e_pop = 1'b1;
    end
    if (e_pop) begin
      e_we   = 1'b1;
      e_addr = exp_q[0][36:32];
      e_data = exp_q[0][31:0];
    end
    check("ll_ready", 64'(bus.ll_ready), 64'(e_ready));
    check("pipe_stall", 64'(bus.pipe_stall), 64'(e_stall));
    check("rf_write", 64'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 64'({e_we, e_addr, e_data}));
    obs_ready = bus.ll_ready;
    obs_stall = bus.pipe_stall;
    obs_we    = bus.rf_we;
    obs_waddr = bus.rf_waddr;
    e_push = lv && e_ready && (lrd != 5'd0);
    if (e_pop) void'(exp_q.pop_front());
    if (e_push) exp_q.push_back({lrd, ld});
    if (e_pop || sz == 0) exp_age = 0;
    else if (exp_age < MAX_WAIT) exp_age++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int n_pipe;
    int waited;
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    exp_age  = 0;
    drive_idle();
    rst_n = 1'b0;
    #2;
    check("reset_rf_we", 64'(bus.rf_we), 64'd0);
    check("reset_ll_ready", 64'(bus.ll_ready), 64'd0);
    check("reset_stall", 64'(bus.pipe_stall), 64'd0);
    check("reset_rf_addr_data", 64'({bus.rf_waddr, bus.rf_wdata}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // pipeline-only writes
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);

    // single LL result in an idle slot
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("ll_ready_stays_high", 64'(obs_ready), 64'd1);
    check("ll_idle_write_addr", 64'(obs_waddr), 64'd7);

    // forced drain under continuous pipeline writes
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    n_pipe = 0;
    seen   = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
      if (obs_stall) seen = 1'b1;
      else if (obs_we && obs_waddr == 5'd9) n_pipe++;
    end
    check("drain_seen", 64'(seen), 64'd1);
    check("pipe_writes_before_drain", 64'(n_pipe), 64'(MAX_WAIT));
    check("drain_addr", 64'(obs_waddr), 64'd3);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    check("pipe_resumes", 64'({obs_stall, obs_waddr}), 64'({1'b0, 5'd9}));

    // fill the FIFO, then hold a third offer until it is accepted
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 32'h101);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd2, 32'h102);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'h103);
      if (obs_ready) seen = 1'b1;
      waited++;
    end
    check("third_push_accepted", 64'(seen), 64'd1);
    check("full_backpressure_seen", 64'(waited > 1), 64'd1);
    idle_cycles(4);
    check("fifo_drained", 64'(exp_q.size()), 64'd0);

    // wb_rd==0 is an idle slot; LL write to r0 is swallowed
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    cycle(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    check("rd0_slot_gives_r4", 64'({obs_we, obs_waddr}), 64'({1'b1, 5'd4}));
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    check("rd0_push_ready", 64'(obs_ready), 64'd1);
    idle_cycles(3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), $urandom());
    end

    // reset with two entries buffered
    idle_cycles(6);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd20, 32'h200);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd21, 32'h201);
    @(negedge clk);
    drive_idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midop_rf_we", 64'(bus.rf_we), 64'd0);
    check("reset_midop_ready", 64'(bus.ll_ready), 64'd0);
    exp_q.delete();
    exp_age = 0;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", 64'(bus.ll_ready), 64'd1);
    check("post_reset_empty", 64'(bus.rf_we), 64'd0);
    idle_cycles(3);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
